// File: rtl/fir_lut_pkg.sv
// Shared constants, FSM state type and sign-extension helper for the
// distributed-arithmetic FIR LUT loader.
package fir_lut_pkg;

  localparam int COEF_W   = 16;
  localparam int NUM_TAPS = 64;
  localparam int GRP      = 8;
  localparam int LUT_W    = 19;
  localparam int ADDR_W   = 11;
  localparam int NUM_GRP  = NUM_TAPS / GRP;
  localparam int SUM_W    = LUT_W + ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FIN
  } state_t;

  // Widen a signed coefficient to LUT width so eight of them can be summed
  // without overflow.
  function automatic logic signed [LUT_W-1:0] sext19(input logic signed [COEF_W-1:0] c);
    return {{(LUT_W-COEF_W){c[COEF_W-1]}}, c};
  endfunction

endpackage

// File: rtl/fir_lut_entry.sv
// Combinational partial-sum generator: adds the coefficients of one group of
// eight taps whose select bit is set. An all-zero select yields zero.
module fir_lut_entry
  import fir_lut_pkg::*;
(
  input  logic [GRP-1:0][COEF_W-1:0] coefs,
  input  logic [GRP-1:0]             sel,
  output logic signed [LUT_W-1:0]    sum
);

  // Sum the selected, sign-extended coefficients of this group.
  always_comb begin
    sum = '0;
    for (int i = 0; i < GRP; i++) begin
      if (sel[i]) begin
        sum = sum + sext19(coefs[i]);
      end
    end
  end

endmodule

// File: rtl/fir_lut_loader.sv
// Sequencer that holds the 64 FIR coefficients and, on start, streams all
// 2048 distributed-arithmetic LUT entries into the filter one per cycle,
// then enables the filter.
// Optional feature macro: FIR_LUT_CHECKSUM_EN adds the lut_sum output, a
// running sum of every entry streamed during the last load.
module fir_lut_loader
  import fir_lut_pkg::*;
(
  input  logic                     clk_slow,
  input  logic                     reset,
  input  logic                     coef_we,
  input  logic [5:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     start,
  output logic signed [LUT_W-1:0]  CIN,
  output logic [ADDR_W-1:0]        CADDR,
  output logic                     CLOAD,
  output logic                     busy,
  output logic                     done,
`ifdef FIR_LUT_CHECKSUM_EN
  output logic signed [SUM_W-1:0]  lut_sum,
`endif
  output logic                     filter_en
);

  // Coefficients stored as [group][tap-in-group] so the active group can be
  // picked directly by the upper address bits.
  logic [NUM_GRP-1:0][GRP-1:0][COEF_W-1:0] coef_q;
  logic [ADDR_W-1:0]                       counter;
  logic signed [LUT_W-1:0]                 entry_sum;
  state_t                                  state;

  fir_lut_entry u_entry (
    .coefs (coef_q[counter[ADDR_W-1:GRP]]),
    .sel   (counter[GRP-1:0]),
    .sum   (entry_sum)
  );

  // Control FSM: coefficient writes and start are honoured only in IDLE;
  // LOAD emits one entry per cycle and stops after address 2047 (no wrap);
  // FIN pulses done and leaves the filter enabled.
  always_ff @(posedge clk_slow) begin
    if (reset) begin
      state     <= IDLE;
      counter   <= '0;
      coef_q    <= '0;
      CIN       <= '0;
      CADDR     <= '0;
      CLOAD     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      filter_en <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          CLOAD <= 1'b0;
          if (coef_we) begin
            coef_q[coef_addr[5:3]][coef_addr[2:0]] <= coef_data;
          end
          if (start) begin
            counter   <= '0;
            busy      <= 1'b1;
            filter_en <= 1'b0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          CIN   <= entry_sum;
          CADDR <= counter;
          CLOAD <= 1'b1;
          if (counter == '1) begin
            state <= FIN;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        FIN: begin
          CLOAD     <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
          filter_en <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FIR_LUT_CHECKSUM_EN
  // Checksum of the streamed entries; cleared when a load is accepted and
  // held after done until the next accepted start or reset.
  always_ff @(posedge clk_slow) begin
    if (reset) begin
      lut_sum <= '0;
    end else if (state == IDLE && start) begin
      lut_sum <= '0;
    end else if (CLOAD) begin
      lut_sum <= lut_sum + {{ADDR_W{CIN[LUT_W-1]}}, CIN};
    end
  end
`endif

endmodule

// File: tb/tb_fir_lut_loader.sv
// Scoreboard bench for fir_lut_loader: stimulus pushes the expected entry
// stream, a negedge monitor pops and compares every CLOAD cycle, and hand
// computed entries are checked against the captured stream after each load.
module tb_fir_lut_loader;
  import fir_lut_pkg::*;

  logic                     clk_slow = 1'b0;
  logic                     reset;
  logic                     coef_we;
  logic [5:0]               coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     start;
  logic signed [LUT_W-1:0]  CIN;
  logic [ADDR_W-1:0]        CADDR;
  logic                     CLOAD;
  logic                     busy;
  logic                     done;
  logic                     filter_en;
`ifdef FIR_LUT_CHECKSUM_EN
  logic signed [SUM_W-1:0]  lut_sum;
  logic signed [SUM_W-1:0]  done_sum;
`endif

  fir_lut_loader dut (
    .clk_slow  (clk_slow),
    .reset     (reset),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .start     (start),
    .CIN       (CIN),
    .CADDR     (CADDR),
    .CLOAD     (CLOAD),
    .busy      (busy),
    .done      (done),
`ifdef FIR_LUT_CHECKSUM_EN
    .lut_sum   (lut_sum),
`endif
    .filter_en (filter_en)
  );

  always #5 clk_slow = ~clk_slow;

  // Edge counter: after edge n (and at the following negedge) cyc == n.
  int cyc = 0;
  always @(posedge clk_slow) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0]       addr;
    logic signed [LUT_W-1:0] cin;
  } exp_t;

  exp_t                    exp_q[$];
  logic signed [COEF_W-1:0] model_coef [NUM_TAPS];
  logic signed [LUT_W-1:0]  seen [2048];
  int n_cmp = 0;
  int n_bad = 0;
  int first_cyc, last_cyc, done_cyc, cload_cnt;
  int t;

  task automatic checkOutput(input string name, input logic signed [31:0] act,
                             input logic signed [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic logic signed [LUT_W-1:0] modelEntry(input int a);
    logic signed [LUT_W-1:0] s;
    int k;
    s = '0;
    k = a / 256;
    for (int i = 0; i < GRP; i++) begin
      if (((a >> i) & 1) != 0) s = s + model_coef[k*GRP + i];
    end
    return s;
  endfunction

  // Monitor: pop and compare every streamed entry, record timing.
  always @(negedge clk_slow) begin
    exp_t e;
    if (CLOAD === 1'b1) begin
      if (cload_cnt == 0) first_cyc = cyc;
      last_cyc = cyc;
      cload_cnt++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_entry", 32'(CADDR), -1);
      end else begin
        e = exp_q.pop_front();
        checkOutput("caddr", 32'(CADDR), 32'(e.addr));
        checkOutput("cin", CIN, e.cin);
      end
      if (!$isunknown(CADDR)) seen[CADDR] = CIN;
    end
    if (done === 1'b1) begin
      done_cyc = cyc;
`ifdef FIR_LUT_CHECKSUM_EN
      done_sum = lut_sum;
`endif
    end
  end

  task automatic writeCoef(input int idx, input int val, input bit update_model);
    coef_we   = 1'b1;
    coef_addr = 6'(idx);
    coef_data = 16'(val);
    if (update_model) model_coef[idx] = 16'(val);
    @(posedge clk_slow);
    #1;
    coef_we = 1'b0;
  endtask

  // Push the full expected stream, pulse start, and record the start edge.
  task automatic applyStimulus(output int t_start);
    exp_t e;
    for (int a = 0; a < 2048; a++) begin
      e.addr = 11'(a);
      e.cin  = modelEntry(a);
      exp_q.push_back(e);
    end
    first_cyc = 0; last_cyc = 0; done_cyc = 0; cload_cnt = 0;
    start = 1'b1;
    @(posedge clk_slow);
    #1;
    start   = 1'b0;
    coef_we = 1'b0;
    t_start = cyc;
    checkOutput("busy_after_start", 32'(busy), 1);
    checkOutput("filter_en_after_start", 32'(filter_en), 0);
  endtask

  task automatic waitCycle(input int c);
    while (cyc < c) @(posedge clk_slow);
    #1;
  endtask

  task automatic checkLoad(input int t_start, input string tag);
    waitCycle(t_start + 2050);
    checkOutput({tag, "_first_entry_cyc"}, first_cyc, t_start + 1);
    checkOutput({tag, "_last_entry_cyc"}, last_cyc, t_start + 2048);
    checkOutput({tag, "_cload_count"}, cload_cnt, 2048);
    checkOutput({tag, "_done_cyc"}, done_cyc, t_start + 2049);
    checkOutput({tag, "_queue_left"}, exp_q.size(), 0);
    checkOutput({tag, "_done_pulse"}, 32'(done), 0);
    checkOutput({tag, "_busy_end"}, 32'(busy), 0);
    checkOutput({tag, "_filter_en"}, 32'(filter_en), 1);
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0; start = 1'b0;
    first_cyc = 0; last_cyc = 0; done_cyc = 0; cload_cnt = 0;
    for (int i = 0; i < NUM_TAPS; i++) model_coef[i] = '0;
    repeat (2) @(posedge clk_slow);
    #1;
    checkOutput("rst_cin", CIN, 0);
    checkOutput("rst_caddr", 32'(CADDR), 0);
    checkOutput("rst_cload", 32'(CLOAD), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_filter_en", 32'(filter_en), 0);
    reset = 1'b0;

    $display("[TB] load with all coefficients zero");
    applyStimulus(t);
    checkLoad(t, "zero");
    repeat (5) @(posedge clk_slow);
    #1;
    checkOutput("filter_en_held", 32'(filter_en), 1);

    $display("[TB] load with coef[i] = i+1");
    for (int i = 0; i < NUM_TAPS; i++) writeCoef(i, i + 1, 1'b1);
    applyStimulus(t);
    checkLoad(t, "ramp");
    checkOutput("ramp_addr_003", seen[11'h003], 3);
    checkOutput("ramp_addr_0ff", seen[11'h0FF], 36);
    checkOutput("ramp_addr_101", seen[11'h101], 9);
    checkOutput("ramp_addr_7ff", seen[11'h7FF], 484);
    for (int k = 0; k < NUM_GRP; k++) checkOutput("ramp_b_zero", seen[k*256], 0);

    $display("[TB] start and coefficient write during a load are ignored");
    applyStimulus(t);
    waitCycle(t + 99);
    start = 1'b1;
    @(posedge clk_slow);
    #1;
    start = 1'b0;
    waitCycle(t + 199);
    writeCoef(0, 5, 1'b0);
    checkLoad(t, "ignore");
    checkOutput("ignore_addr_001", seen[11'h001], 1);
    applyStimulus(t);
    checkLoad(t, "reload");
    checkOutput("reload_addr_001", seen[11'h001], 1);

    $display("[TB] extreme coefficients, last write in the start cycle");
    for (int i = 8; i < 16; i++) writeCoef(i, -32768, 1'b1);
    for (int i = 16; i < 23; i++) writeCoef(i, 32767, 1'b1);
    coef_we = 1'b1; coef_addr = 6'd23; coef_data = 16'sd32767;
    model_coef[23] = 16'sd32767;
    applyStimulus(t);
    checkLoad(t, "extreme");
    checkOutput("extreme_addr_1ff", seen[11'h1FF], -262144);
    checkOutput("extreme_addr_2ff", seen[11'h2FF], 262136);
    checkOutput("extreme_addr_180", seen[11'h180], -32768);

    $display("[TB] reset in the middle of a load");
    applyStimulus(t);
    waitCycle(t + 999);
    reset = 1'b1;
    @(posedge clk_slow);
    #1;
    reset = 1'b0;
    checkOutput("abort_cload", 32'(CLOAD), 0);
    checkOutput("abort_caddr", 32'(CADDR), 0);
    checkOutput("abort_cin", CIN, 0);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_filter_en", 32'(filter_en), 0);
    exp_q.delete();
    for (int i = 0; i < NUM_TAPS; i++) model_coef[i] = '0;
    applyStimulus(t);
    checkLoad(t, "cleared");
    checkOutput("cleared_addr_000", seen[11'h000], 0);
    checkOutput("cleared_addr_1ff", seen[11'h1FF], 0);
    checkOutput("cleared_addr_7ff", seen[11'h7FF], 0);

`ifdef FIR_LUT_CHECKSUM_EN
    $display("[TB] checksum with all coefficients one");
    for (int i = 0; i < NUM_TAPS; i++) writeCoef(i, 1, 1'b1);
    applyStimulus(t);
    checkLoad(t, "checksum");
    checkOutput("checksum_at_done", done_sum, 8192);
    checkOutput("checksum_held", lut_sum, 8192);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_lut_loader.md
Name: fir_lut_loader

Overview:
- Sequencer that configures the distributed-arithmetic FIR filter.
- Holds the 64 signed filter coefficients written by the host.
- On command, computes all 2048 partial-sum LUT entries and streams them into the filter's CIN/CADDR/CLOAD port, one entry per cycle.
- Then raises filter_en, which drives the filter's valid_in.
- Sits between the host/test harness and fir_filter, in the slow clock domain.

Parameters:
- COEF_W, 16, coefficient width (signed).
- NUM_TAPS, 64, number of coefficients.
- GRP, 8, taps per LUT group.
- LUT_W, 19, LUT entry width; equals COEF_W+log2(GRP).
- ADDR_W, 11, LUT address width; equals log2(NUM_TAPS/GRP)+GRP.

Ports:
- clk_slow  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  6  coefficient index 0..63.
- coef_data  in  COEF_W  signed coefficient value.
- start  in  1  single-cycle pulse; begins LUT load.
- CIN  out  LUT_W  signed LUT entry to filter.
- CADDR  out  ADDR_W  LUT address to filter.
- CLOAD  out  1  LUT write enable to filter.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when load completes.
- filter_en  out  1  drives filter valid_in.

Behaviour:
- Clock and reset: one clock (clk_slow); reset is synchronous and active-high.
- Reset values:
  - CIN=0, CADDR=0, CLOAD=0, busy=0, done=0, filter_en=0.
  - Entry counter=0; all 64 coefficient registers=0; FSM=IDLE.
- FSM states: IDLE, LOAD, FIN.
  - IDLE -> LOAD on start; counter<=0, busy<=1, filter_en<=0.
  - LOAD: every cycle, CIN<=entry(counter), CADDR<=counter, CLOAD<=1, counter<=counter+1. Leave to FIN when counter==2047 has been emitted.
  - FIN (one cycle): CLOAD<=0, busy<=0, done<=1, filter_en<=1. Then -> IDLE.
- Timing, start sampled at edge t:
  - Entry 0 is on the outputs during cycle t+2.
  - Entry 2047 is on the outputs during cycle t+2049.
  - CLOAD=0, done=1 and filter_en=1 during cycle t+2050.
  - Total load time 2050 cycles; exactly 2048 cycles have CLOAD=1.
- Entry arithmetic, for address a:
  - k=a[10:8], b=a[7:0].
  - entry = sum over i=0..7 with b[i]=1 of sext19(coef[8k+i]).
  - Computed combinationally from the coefficient regs and registered into CIN.
  - No overflow is possible: the range is -262144..262136.
  - Entries with b=0 are 0.
- Coefficient writes:
  - Accepted in IDLE only; ignored (no effect) in LOAD/FIN.
  - coef_we and start in the same IDLE cycle: the write is committed and the load uses the new value.
- start while busy, or during FIN: ignored.
- filter_en stays 1 after the load until the next accepted start or reset.
- reset during LOAD: all outputs return to reset values on the next edge and the load is abandoned. Coefficients are cleared.
- CADDR wrap: the counter never wraps. Termination is on 2047, not overflow.

Optional Feature:
- Macro: FIR_LUT_CHECKSUM_EN
- Defined:
  - Adds output lut_sum [LUT_W+ADDR_W-1:0] (signed, 30 bits).
  - Cleared on reset and on accepted start.
  - Accumulates sext(CIN) on every cycle CLOAD=1.
  - Final value is valid when done=1 and is held until the next start/reset.
- Undefined: port and accumulator absent; all other behaviour identical.

Decomposition:
- Package fir_lut_pkg holds:
  - constants COEF_W, LUT_W, ADDR_W, GRP, NUM_TAPS;
  - FSM state enum {IDLE, LOAD, FIN};
  - function sext19.
- One sub-module, fir_lut_entry: purely combinational.
  - Inputs: 8 coefficients and an 8-bit select.
  - Output: the 19-bit sum.
  - The parent muxes the group of 8 coefficients by CADDR[10:8].

Test Plan:
- All coefs 0, start -> 2048 CLOAD cycles, CADDR 0..2047 in order, CIN=0 throughout. done pulses at t+2050; filter_en=1 thereafter.
- coef[i]=i+1 for i=0..63, start:
  - CADDR=3 -> CIN=3.
  - CADDR=0x0FF -> 36.
  - CADDR=0x101 -> 9.
  - CADDR=0x7FF -> 484 (sum 57..64).
  - Every b=0 address -> 0.
- coef[8..15]=-32768 and coef[16..23]=32767:
  - CADDR=0x1FF -> CIN=-262144 (19'h40000).
  - CADDR=0x2FF -> 262136.
  - CADDR=0x180 -> -32768.
- Ignored commands during LOAD:
  - start pulse at t+100 -> ignored; load ends at t+2050 unchanged.
  - coef_we to index 0 with 5 at t+200 -> entries unaffected; a second load afterwards still uses the old value.
- reset asserted at t+1000 -> next cycle CLOAD=0, CADDR=0, busy=0, filter_en=0. A new start then produces entry 0 at CADDR 0 with CIN=0 (coefs cleared).
- FIR_LUT_CHECKSUM_EN, coef[i]=1 for all i -> lut_sum = 8*(256*8/2) = 8192 when done=1.
